// File: rtl/slot_allocator.sv
// slot_allocator: 256-entry free-slot bitmap with a req/gnt allocation port,
// a release port and a flush. The highest-numbered free slot is granted with
// zero-cycle latency from request to grant.
// Optional feature macro: SLOT_ALLOC_ERR_EN enables a sticky double-release
// error flag; without it err is tied low and no flag register exists.
module slot_allocator #(
  parameter int NSLOTS = 256,
  parameter int IDX_W  = 8,
  parameter int CNT_W  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             rel_valid,
  input  logic [IDX_W-1:0] rel_idx,
  input  logic             flush,
  output logic [CNT_W-1:0] free_cnt,
  output logic             empty,
  output logic             full,
  output logic             err
);

  logic [NSLOTS-1:0] free_map_reg;
  logic [NSLOTS-1:0] free_map_next;
  logic [CNT_W-1:0]  free_cnt_reg;
  logic [CNT_W-1:0]  free_cnt_next;
  logic [IDX_W-1:0]  enc_idx;
  logic              rel_hit;
  logic              rel_ok;

  // Status flags come only from the registered count.
  assign free_cnt  = free_cnt_reg;
  assign empty     = (free_cnt_reg == '0);
  assign full      = (free_cnt_reg == CNT_W'(NSLOTS));
  assign alloc_gnt = alloc_req & ~empty;
  assign alloc_idx = enc_idx;

  // A release is only effective when the slot is currently allocated.
  assign rel_hit = free_map_reg[rel_idx];
  assign rel_ok  = rel_valid & ~rel_hit;

  // Priority encoder: highest set bit of the free bitmap wins.
  always_comb begin
    enc_idx = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (free_map_reg[i]) enc_idx = IDX_W'(i);
    end
  end

  // Per-slot next state: flush frees everything, otherwise grant clears and
  // a valid release sets. A release of the granted slot is a double release
  // (the bit was free), so rel_ok is low and the grant alone clears it.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOTS; gi++) begin : g_slot
      assign free_map_next[gi] = flush |
                                 (free_map_reg[gi] & ~(alloc_gnt & (alloc_idx == IDX_W'(gi)))) |
                                 (rel_ok & (rel_idx == IDX_W'(gi)));
    end
  endgenerate

  // Free count tracks popcount of the bitmap: +1 release, -1 grant.
  always_comb begin
    free_cnt_next = free_cnt_reg;
    if (flush) begin
      free_cnt_next = CNT_W'(NSLOTS);
    end else begin
      case ({rel_ok, alloc_gnt})
        2'b10:   free_cnt_next = free_cnt_reg + CNT_W'(1);
        2'b01:   free_cnt_next = free_cnt_reg - CNT_W'(1);
        default: free_cnt_next = free_cnt_reg;
      endcase
    end
  end

  // Bitmap and count registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_map_reg <= '1;
      free_cnt_reg <= CNT_W'(NSLOTS);
    end else begin
      free_map_reg <= free_map_next;
      free_cnt_reg <= free_cnt_next;
    end
  end

`ifdef SLOT_ALLOC_ERR_EN
  logic err_reg;
  logic dbl_rel;

  // A release landing on a free slot is a double release; ignored under flush.
  assign dbl_rel = rel_valid & rel_hit & ~flush;
  assign err     = err_reg;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (dbl_rel) begin
      err_reg <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_slot_allocator.sv
// Scoreboard bench for slot_allocator: the stimulus process pushes the
// hand-computed expected outputs for each cycle, a negedge monitor pops and
// compares them and also checks free_cnt against the bitmap popcount.
module tb_slot_allocator;

`ifdef SLOT_ALLOC_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req = 1'b0;
  logic       alloc_gnt;
  logic [7:0] alloc_idx;
  logic       rel_valid = 1'b0;
  logic [7:0] rel_idx = '0;
  logic       flush = 1'b0;
  logic [8:0] free_cnt;
  logic       empty;
  logic       full;
  logic       err;

  slot_allocator dut (
    .clk       (clk),
    .rst       (rst),
    .alloc_req (alloc_req),
    .alloc_gnt (alloc_gnt),
    .alloc_idx (alloc_idx),
    .rel_valid (rel_valid),
    .rel_idx   (rel_idx),
    .flush     (flush),
    .free_cnt  (free_cnt),
    .empty     (empty),
    .full      (full),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       chk_gnt;
    logic       gnt;
    logic       chk_idx;
    logic [7:0] idx;
    logic [8:0] cnt;
    logic       err;
    logic       chk_bit;
    int         bit_i;
    logic       bit_v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  logic started = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s txn=%0d actual=%0d required=%0d", nm, txn, act, req);
    end
  endtask

  // Monitor: one comparison set per transaction, plus the count invariant.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      txn++;
      $display("txn %0d %s: gnt=%0b idx=%0d cnt=%0d empty=%0b full=%0b err=%0b",
               txn, e.name, alloc_gnt, alloc_idx, free_cnt, empty, full, err);
      if (e.chk_gnt) check({e.name, ".gnt"}, 32'(alloc_gnt), 32'(e.gnt));
      if (e.chk_idx) check({e.name, ".idx"}, 32'(alloc_idx), 32'(e.idx));
      check({e.name, ".cnt"},   32'(free_cnt), 32'(e.cnt));
      check({e.name, ".empty"}, 32'(empty), 32'(e.cnt == 9'd0));
      check({e.name, ".full"},  32'(full),  32'(e.cnt == 9'd256));
      check({e.name, ".err"},   32'(err),   32'(e.err));
      if (e.chk_bit) check({e.name, ".bit"}, 32'(dut.free_map_reg[e.bit_i]), 32'(e.bit_v));
    end
    if (started && !rst)
      check("popcount", 32'(free_cnt), 32'($countones(dut.free_map_reg)));
  end

  // Drive one cycle of inputs and queue what the outputs must be in it.
  task automatic step(input string nm, input logic req, input logic rv, input logic [7:0] ri,
                      input logic fl, input logic rs,
                      input logic chk_gnt, input logic gnt, input logic chk_idx,
                      input logic [7:0] idx, input logic [8:0] cnt, input logic e_err,
                      input logic chk_bit = 1'b0, input int bit_i = 0, input logic bit_v = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    alloc_req = req; rel_valid = rv; rel_idx = ri; flush = fl; rst = rs;
    e.name = nm; e.chk_gnt = chk_gnt; e.gnt = gnt; e.chk_idx = chk_idx; e.idx = idx;
    e.cnt = cnt; e.err = e_err; e.chk_bit = chk_bit; e.bit_i = bit_i; e.bit_v = bit_v;
    exp_q.push_back(e);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout txn=%0d actual=running required=finished", txn);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset cycle: outputs undefined before the first edge, not checked.
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    started = 1'b1;
    // Post-reset state, then gnt follows req.
    step("reset",     0, 0, 0, 0, 0, 1, 0, 1, 8'd255, 9'd256, 1'b0);
    // 1. Drain all 256 slots.
    for (int k = 0; k < 256; k++)
      step("drain", 1, 0, 0, 0, 0, 1, 1, 1, 8'(255 - k), 9'(256 - k), 1'b0);
    step("drained",   1, 0, 0, 0, 0, 1, 0, 0, 8'd0, 9'd0, 1'b0);
    // 2. Release 17 then 200, then grant 200 then 17.
    step("rel17",     0, 1, 8'd17,  0, 0, 1, 0, 0, 8'd0, 9'd0, 1'b0);
    step("rel200",    0, 1, 8'd200, 0, 0, 1, 0, 1, 8'd17, 9'd1, 1'b0);
    step("gnt200",    1, 0, 0, 0, 0, 1, 1, 1, 8'd200, 9'd2, 1'b0);
    step("gnt17",     1, 0, 0, 0, 0, 1, 1, 1, 8'd17, 9'd1, 1'b0);
    step("empty2",    0, 0, 0, 0, 0, 1, 0, 0, 8'd0, 9'd0, 1'b0);
    // 3. Free 255 and 254, then grant 255 while releasing 100.
    step("rel255",    0, 1, 8'd255, 0, 0, 1, 0, 0, 8'd0, 9'd0, 1'b0);
    step("rel254",    0, 1, 8'd254, 0, 0, 1, 0, 1, 8'd255, 9'd1, 1'b0);
    step("gnt_rel",   1, 1, 8'd100, 0, 0, 1, 1, 1, 8'd255, 9'd2, 1'b0, 1, 100, 1'b0);
    step("after_gr",  0, 0, 0, 0, 0, 1, 0, 1, 8'd254, 9'd2, 1'b0, 1, 100, 1'b1);
    step("gnt254",    1, 0, 0, 0, 0, 1, 1, 1, 8'd254, 9'd2, 1'b0);
    step("only100",   0, 0, 0, 0, 0, 1, 0, 1, 8'd100, 9'd1, 1'b0);
    // Flush with a release of a free slot: no error.
    step("flush_rel", 0, 0, 0, 1, 0, 1, 0, 1, 8'd100, 9'd1, 1'b0);
    step("fr_rel5",   0, 1, 8'd5, 1, 0, 1, 0, 1, 8'd255, 9'd256, 1'b0);
    // 4. Double release of free slot 5.
    step("dbl5",      0, 1, 8'd5, 0, 0, 1, 0, 1, 8'd255, 9'd256, 1'b0);
    step("dbl5_aft",  0, 0, 0, 0, 0, 1, 0, 1, 8'd255, 9'd256, ERR_EN, 1, 5, 1'b1);
    // 5. Allocate 10 then flush.
    for (int k = 0; k < 10; k++)
      step("alloc10", 1, 0, 0, 0, 0, 1, 1, 1, 8'(255 - k), 9'(256 - k), ERR_EN);
    step("flush",     0, 0, 0, 1, 0, 1, 0, 1, 8'd245, 9'd246, ERR_EN);
    step("flushed",   0, 0, 0, 0, 0, 1, 0, 1, 8'd255, 9'd256, ERR_EN);
    // 6. Allocate 3, then reset together with a request.
    for (int k = 0; k < 3; k++)
      step("alloc3",  1, 0, 0, 0, 0, 1, 1, 1, 8'(255 - k), 9'(256 - k), ERR_EN);
    step("rst_req",   1, 0, 0, 0, 1, 0, 0, 1, 8'd252, 9'd253, ERR_EN);
    step("post_rst",  0, 0, 0, 0, 0, 1, 0, 1, 8'd255, 9'd256, 1'b0);
    step("post_req",  1, 0, 0, 0, 0, 1, 1, 1, 8'd255, 9'd256, 1'b0);
    step("idle",      0, 0, 0, 0, 0, 1, 0, 1, 8'd254, 9'd255, 1'b0);
    @(posedge clk);
    @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
